// File: rtl/perf_counter_bank.sv
// perf_counter_bank: parametrised bank of event counters with per-channel
// enable, stall gating, wrap or saturate on overflow, sticky overflow flags,
// an atomic snapshot into a shadow bank, and a small MMIO register port.
module perf_counter_bank #(
  parameter int                 NUM_CNT         = 4,
  parameter int                 CNT_WIDTH       = 32,
  parameter bit                 SATURATE        = 1'b0,
  parameter logic [NUM_CNT-1:0] STALL_GATE_MASK = 4'hE,
  parameter logic [NUM_CNT-1:0] RESET_EN        = 4'hF
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               Stall,
  input  logic [NUM_CNT-1:0] event_in,
  input  logic [3:0]         reg_idx,
  input  logic               reg_re,
  input  logic               reg_we,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_rvalid,
  output logic               ovf_irq
);

  localparam logic [3:0] IDX_CTRL   = 4'hC;
  localparam logic [3:0] IDX_STATUS = 4'hD;
  localparam logic [3:0] IDX_CMD    = 4'hE;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] shd_q [NUM_CNT];
  logic [NUM_CNT-1:0]   en_q;
  logic                 shadow_sel_q;
  logic [NUM_CNT-1:0]   ovf_q;

  logic [NUM_CNT-1:0]   cnt_wr;
  logic [NUM_CNT-1:0]   inc;
  logic [NUM_CNT-1:0]   at_max;
  logic [NUM_CNT-1:0]   ovf_set;
  logic                 ctrl_wr;
  logic                 status_wr;
  logic                 clear_all;
  logic                 snapshot;
  logic                 rd_acc;
  logic [31:0]          rd_data;

  // Register-port decode: a write always beats a simultaneous read.
  assign ctrl_wr   = reg_we && (reg_idx == IDX_CTRL);
  assign status_wr = reg_we && (reg_idx == IDX_STATUS);
  assign clear_all = reg_we && (reg_idx == IDX_CMD) && reg_wdata[0];
  assign snapshot  = reg_we && (reg_idx == IDX_CMD) && reg_wdata[1];
  assign rd_acc    = reg_re && !reg_we;

  // Per-channel increment qualification and overflow detection.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_wr  = '0;
    inc     = '0;
    at_max  = '0;
    ovf_set = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_wr[i]  = reg_we && (reg_idx == 4'(i));
      at_max[i]  = &cnt_q[i];
      inc[i]     = event_in[i] & en_q[i] & ~(Stall & STALL_GATE_MASK[i]);
      // An event dropped by a same-cycle write or clear cannot overflow.
      ovf_set[i] = inc[i] & at_max[i] & ~cnt_wr[i] & ~clear_all;
    end
  end

  // Read mux over pre-edge register state.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      IDX_CTRL: begin
        rd_data[NUM_CNT-1:0] = en_q;
        rd_data[16]          = shadow_sel_q;
      end
      IDX_STATUS: rd_data[NUM_CNT-1:0] = ovf_q;
      default: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (reg_idx == 4'(i)) begin
            rd_data = shadow_sel_q ? 32'(shd_q[i]) : 32'(cnt_q[i]);
          end
        end
      end
    endcase
  end

  // Live and shadow counters: clear > write > increment; snapshot sees pre-update values.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
    if (reset) begin
      // NOTE: the counter arrays are reset in full; software may read any of them straight after reset.
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
        shd_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (snapshot) shd_q[i] <= cnt_q[i];
        if (clear_all) begin
          cnt_q[i] <= '0;
        end else if (cnt_wr[i]) begin
          cnt_q[i] <= reg_wdata[CNT_WIDTH-1:0];
        end else if (inc[i] && !(SATURATE && at_max[i])) begin
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Control, sticky overflow flags and the registered interrupt.
  always_ff @(posedge CLK) begin
    if (reset) begin
      en_q         <= RESET_EN;
      shadow_sel_q <= 1'b0;
      ovf_q        <= '0;
      ovf_irq      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q         <= reg_wdata[NUM_CNT-1:0];
        shadow_sel_q <= reg_wdata[16];
      end
      // A new overflow wins over a same-cycle write-1-to-clear of that bit.
      if (clear_all) begin
        ovf_q <= '0;
      end else begin
        ovf_q <= (ovf_q & ~(status_wr ? reg_wdata[NUM_CNT-1:0] : '0)) | ovf_set;
      end
      ovf_irq <= |(ovf_q & en_q);
    end
  end

  // Read port: one-cycle latency, data held while no read completes.
  always_ff @(posedge CLK) begin
    if (reset) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= rd_acc;
      if (rd_acc) reg_rdata <= rd_data;
    end
  end

endmodule
